// File: rtl/jtag_pkg.sv
// Shared types and constants for the USER4 JTAG session controller.
// Pure declarations, no logic.
package jtag_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPLOAD = 2'd1,
        BUSY   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_RESULT_WIDTH = 128;

    // 7-series USER4 instruction opcode
    localparam logic [5:0] IR_USER4 = 6'h23;

endpackage

// File: rtl/jtag_byte_deser.sv
// Upload deserializer: drops leading skip bits, assembles LSB-first bytes.
// byte_valid one tck after the 8th data bit; no backpressure (one byte per 8 tck).
module jtag_byte_deser #(
    parameter int SKIP_BITS = 1
) (
    input  logic       tck,
    input  logic       rst,
    input  logic       start,
    input  logic       shift_en,
    input  logic       finish,
    input  logic       tdi,
    output logic       byte_done,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_error
);

    localparam int SKW = (SKIP_BITS < 1) ? 1 : $clog2(SKIP_BITS + 1);

    logic [SKW-1:0] skip_q, skip_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     asm_q, asm_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;

    always_comb begin
        skip_d    = skip_q;
        bit_d     = bit_q;
        asm_d     = asm_q;
        data_d    = data_q;
        ferr_d    = ferr_q;
        byte_done = 1'b0;

        if (start) begin
            skip_d = SKW'(SKIP_BITS);
            bit_d  = 3'd0;
            asm_d  = 8'd0;
        end else if (shift_en) begin
            if (skip_q != '0) begin
                skip_d = skip_q - SKW'(1);
            end else begin
                asm_d = {tdi, asm_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    byte_done = 1'b1;
                    data_d    = {tdi, asm_q[7:1]};
                end
            end
        end

        // End of scan: a partial byte is a framing fault and is discarded
        if (finish) begin
            if (bit_q != 3'd0) begin
                ferr_d = 1'b1;
            end
            bit_d = 3'd0;
            asm_d = 8'd0;
        end

        valid_d = byte_done;
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            skip_q  <= '0;
            bit_q   <= 3'd0;
            asm_q   <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            skip_q  <= skip_d;
            bit_q   <= bit_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid    = valid_q;
    assign byte_data     = data_q;
    assign framing_error = ferr_q;

endmodule

// File: rtl/jtag_session_ctrl.sv
// Session sequencer over USER4: upload bytes to the solver, wait, then read the result back.
// Byte and end_of_file pulses lag their TAP edge by one tck; the solver cannot stall the host.
module jtag_session_ctrl
    import jtag_pkg::*;
#(
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    parameter int SKIP_BITS    = 1,
    parameter int COUNT_WIDTH  = 21
) (
    input  logic                    tck,
    input  logic                    test_logic_reset,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    input  logic                    tdi,
    output logic                    tdo,
    output logic                    byte_valid,
    output logic [7:0]              byte_data,
    output logic                    end_of_file,
    input  logic                    result_valid,
    input  logic [RESULT_WIDTH-1:0] result,
    output logic [COUNT_WIDTH-1:0]  byte_count,
    output logic                    framing_error
);

    state_t                  state_q, state_d;
    logic [RESULT_WIDTH-1:0] sr_q, sr_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    eof_q, eof_d;
    logic                    des_start, des_shift, des_finish, byte_done;

    logic cap, shf, upd;
    assign cap = ir_is_user & capture_dr;
    assign shf = ir_is_user & shift_dr & ~capture_dr;
    assign upd = ir_is_user & update_dr;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        count_d    = count_q;
        eof_d      = 1'b0;
        des_start  = 1'b0;
        des_shift  = 1'b0;
        des_finish = 1'b0;

        if (byte_done && (count_q != '1)) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (cap) begin
                    des_start = 1'b1;
                    state_d   = UPLOAD;
                end
            end
            UPLOAD: begin
                des_shift = shf;
                if (upd) begin
                    des_finish = 1'b1;
                    eof_d      = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Host sees zeros until the solver finishes and keeps polling
                if (cap) begin
                    sr_d = '0;
                end else if (shf) begin
                    sr_d = {1'b0, sr_q[RESULT_WIDTH-1:1]};
                end
                if (result_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cap) begin
                    sr_d = result;
                end else if (shf) begin
                    sr_d = {tdi, sr_q[RESULT_WIDTH-1:1]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            count_q <= '0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            count_q <= count_d;
            eof_q   <= eof_d;
        end
    end

    jtag_byte_deser #(
        .SKIP_BITS(SKIP_BITS)
    ) u_deser (
        .tck          (tck),
        .rst          (test_logic_reset),
        .start        (des_start),
        .shift_en     (des_shift),
        .finish       (des_finish),
        .tdi          (tdi),
        .byte_done    (byte_done),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .framing_error(framing_error)
    );

    assign tdo         = sr_q[0];
    assign end_of_file = eof_q;
    assign byte_count  = count_q;

endmodule

// File: doc/jtag_session_ctrl.md
Name: jtag_session_ctrl

Overview:
- Sequences one user-logic session over the USER4 DR chain: upload phase, solve phase, readback phase.
- Upload: bytes streamed LSB-first by the host are deserialized and handed to the puzzle solver.
- End of upload: the solver is told when the upload ends. Its result is then latched and shifted out on later DR scans.
- Placement: inside user_logic, between the BSCANE2-style TAP outputs and the solver datapath.

Parameters:
- RESULT_WIDTH, 128, width of the solver result and of the readback scan.
- SKIP_BITS, 1, leading shift_dr bits discarded at the start of the upload scan (ARM DAP bypass bit).
- COUNT_WIDTH, 21, width of the uploaded-byte counter.

Ports:
- tck  in  1  JTAG clock; all state changes on posedge.
- test_logic_reset  in  1  asynchronous active-high reset.
- ir_is_user  in  1  IR holds USER4; DR qualifiers are ignored while low.
- capture_dr  in  1  TAP in Capture-DR.
- shift_dr  in  1  TAP in Shift-DR; tdi is sampled on posedge.
- update_dr  in  1  TAP in Update-DR.
- tdi  in  1  serial data in.
- tdo  out  1  serial data out; equals shift register bit 0.
- byte_valid  out  1  one-cycle pulse; byte_data is valid.
- byte_data  out  8  assembled byte.
- end_of_file  out  1  one-cycle pulse after the last upload byte.
- result_valid  in  1  solver result ready; held high until reset.
- result  in  RESULT_WIDTH  solver result.
- byte_count  out  COUNT_WIDTH  bytes emitted so far; saturates at all-ones.
- framing_error  out  1  sticky; upload scan length minus SKIP_BITS was not a multiple of 8.

Behaviour:
- Reset values (async, on test_logic_reset=1):
  - state=IDLE; byte_valid=0; byte_data=0; end_of_file=0; byte_count=0; framing_error=0.
  - Shift register=0, so tdo=0. Skip counter=0; bit counter=0.
- DR qualifiers are honoured only when ir_is_user=1. Otherwise state and registers hold.
- States and transitions:
  - IDLE: capture_dr -> UPLOAD; skip counter loaded with SKIP_BITS, bit counter cleared.
  - UPLOAD: on each shift_dr posedge, if skip counter >0, decrement it and discard tdi. Otherwise shift tdi into bit [7] of the byte register (shift right) and increment the bit counter mod 8. When the 8th bit is sampled, the next cycle has byte_valid=1, byte_data=the assembled byte, and byte_count+1.
  - UPLOAD, on update_dr: if the bit counter is non-zero, set framing_error and drop the partial byte. Pulse end_of_file on the next cycle, after any final byte_valid (same-cycle ordering: byte_valid cycle N, end_of_file no earlier than N+1). Go to BUSY.
  - BUSY: capture_dr loads the shift register with 0, so the host reads zero and re-polls. shift_dr shifts right with 0 in at the MSB. On result_valid=1 -> DONE.
  - DONE: capture_dr loads result into the shift register. shift_dr shifts right with tdi into the MSB, so tdo presents result bit j on the j-th shift. Repeat scans re-capture the same result.
- capture_dr in UPLOAD or BUSY never restarts the upload. A new upload requires reset.
- result_valid arriving in IDLE or UPLOAD is ignored until BUSY is entered; it is then seen on the first BUSY cycle.
- The solver has no backpressure: at most one byte per 8 tck.
- Reset mid-upload discards the partial byte; no end_of_file is emitted.
- Simultaneous capture_dr and shift_dr never occur (TAP-guaranteed). If they do, capture wins.

Decomposition:
- Shared package jtag_pkg:
  - state_t enum {IDLE, UPLOAD, BUSY, DONE}.
  - RESULT_WIDTH default constant.
  - IR_USER4 encoding.
- Sub-module jtag_byte_deser: skip counter, bit counter, byte register, byte_valid and framing flag.
- The parent holds the FSM, the readback shift register and byte_count.

Test Plan:
- Upload "ab\n": 1 skip bit plus 24 bits -> byte_valid pulses with 0x61, 0x62, 0x0A; byte_count=3; end_of_file 1 cycle after the last byte; framing_error=0.
- Readback scan while BUSY (result_valid=0) -> 128 tdo bits all 0. Assert result_valid with result=0x1234ABCD -> next scan returns 0x1234ABCD LSB-first; a second scan returns the same value.
- Upload of 1+13 bits -> one byte emitted; framing_error=1; end_of_file still pulses; FSM reaches BUSY.
- Pulse test_logic_reset after 4 data bits -> all outputs reset; a fresh upload of "x" yields exactly one byte 0x78.
- ir_is_user=0 while capture_dr, shift_dr and tdi toggle for 16 bits -> no byte_valid, state stays IDLE, tdo=0.
- result_valid held high from reset, then upload "1" -> end_of_file pulses, then DONE; the readback scan returns result.
